// File: rtl/pipe_controller_if.sv
// Control-path bundle between the pipelined datapath/hazard unit and pipe_controller.
// The IllegalOp signal exists only when ILLEGAL_OP_TRAP_EN is defined.
interface pipe_controller_if #(
  parameter int ALU_CTL_W = 3,
  parameter int OP_W      = 6
);
  logic [OP_W-1:0]      Opcode;
  logic [OP_W-1:0]      Funct;
  logic                 ZeroM;
  logic                 StallE;
  logic                 FlushE;
  logic                 j;
  logic                 FlushD;
  logic                 RegDstE;
  logic                 ALUSrcB;
  logic [ALU_CTL_W-1:0] ALUControlE;
  logic                 RegWriteE;
  logic                 MemToRegE;
  logic                 MemWrite;
  logic                 Branch;
  logic                 RegWriteM;
  logic                 PCSrc;
  logic                 RegWriteW;
  logic                 MemToReg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                 IllegalOp;
`endif

  modport master (
    output Opcode, Funct, ZeroM, StallE, FlushE,
    input  j, FlushD, RegDstE, ALUSrcB, ALUControlE, RegWriteE, MemToRegE,
           MemWrite, Branch, RegWriteM, PCSrc, RegWriteW, MemToReg
`ifdef ILLEGAL_OP_TRAP_EN
    , input IllegalOp
`endif
  );

  modport slave (
    input  Opcode, Funct, ZeroM, StallE, FlushE,
    output j, FlushD, RegDstE, ALUSrcB, ALUControlE, RegWriteE, MemToRegE,
           MemWrite, Branch, RegWriteM, PCSrc, RegWriteW, MemToReg
`ifdef ILLEGAL_OP_TRAP_EN
    , output IllegalOp
`endif
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipelined main/ALU decoder: decodes in D, carries control through E/M/W, resolves branches in M.
// Optional sticky illegal-instruction trap enabled by defining ILLEGAL_OP_TRAP_EN.
module pipe_controller #(
  parameter int ALU_CTL_W = 3,
  parameter int OP_W      = 6
) (
  input logic             clk,
  input logic             reset,
  pipe_controller_if.slave bus
);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] FN_ADD   = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] FN_SUB   = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] FN_AND   = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] FN_OR    = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] FN_SLT   = OP_W'(6'b101010);

  localparam logic [ALU_CTL_W-1:0] ALU_AND = ALU_CTL_W'(3'b000);
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = ALU_CTL_W'(3'b001);
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = ALU_CTL_W'(3'b010);
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = ALU_CTL_W'(3'b110);
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = ALU_CTL_W'(3'b111);

  logic                 reg_write_d, reg_dst_d, alu_src_d, branch_d, mem_write_d, mem_to_reg_d;
  logic [1:0]           alu_op_d;
  logic [ALU_CTL_W-1:0] alu_ctl_d;
  logic                 j_d;

  logic                 reg_write_p0, reg_dst_p0, alu_src_p0, branch_p0, mem_write_p0, mem_to_reg_p0;
  logic [ALU_CTL_W-1:0] alu_ctl_p0;
  logic                 reg_write_p1, branch_p1, mem_write_p1, mem_to_reg_p1;
  logic                 reg_write_p2, mem_to_reg_p2;
  logic                 pcsrc;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_d, illegal_op;

  assign illegal_d = !(bus.Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) ||
                     ((bus.Opcode == OP_RTYPE) &&
                      !(bus.Funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}));
`endif

  // D: main decode, then ALU decode; unknown opcodes fall through as bubbles
  always_comb begin
    reg_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_op_d     = 2'b00;
    alu_ctl_d    = ALU_ADD;
    j_d          = 1'b0;
    case (bus.Opcode)
      OP_RTYPE: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_op_d = 2'b10; end
      OP_LW:    begin reg_write_d = 1'b1; alu_src_d = 1'b1; mem_to_reg_d = 1'b1; end
      OP_SW:    begin alu_src_d = 1'b1; mem_write_d = 1'b1; end
      OP_BEQ:   begin branch_d = 1'b1; alu_op_d = 2'b01; end
      OP_ADDI:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; end
      OP_J:     j_d = 1'b1;
      default:  ;
    endcase
    case (alu_op_d)
      2'b01: alu_ctl_d = ALU_SUB;
      2'b10: begin
        case (bus.Funct)
          FN_ADD:  alu_ctl_d = ALU_ADD;
          FN_SUB:  alu_ctl_d = ALU_SUB;
          FN_AND:  alu_ctl_d = ALU_AND;
          FN_OR:   alu_ctl_d = ALU_OR;
          FN_SLT:  alu_ctl_d = ALU_SLT;
          default: begin alu_ctl_d = ALU_ADD; reg_write_d = 1'b0; end
        endcase
      end
      default: alu_ctl_d = ALU_ADD;
    endcase
`ifdef ILLEGAL_OP_TRAP_EN
    // once trapped, nothing new enters the pipe
    if (illegal_op) begin
      reg_write_d  = 1'b0;
      reg_dst_d    = 1'b0;
      alu_src_d    = 1'b0;
      branch_d     = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      alu_ctl_d    = ALU_ADD;
    end
`endif
  end

  assign pcsrc = branch_p1 & bus.ZeroM;

  // D -> E: taken branch and FlushE bubble, StallE holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || pcsrc || bus.FlushE) begin
      reg_write_p0  <= 1'b0;
      reg_dst_p0    <= 1'b0;
      alu_src_p0    <= 1'b0;
      branch_p0     <= 1'b0;
      mem_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
      alu_ctl_p0    <= ALU_ADD;
    end else if (!bus.StallE) begin
      reg_write_p0  <= reg_write_d;
      reg_dst_p0    <= reg_dst_d;
      alu_src_p0    <= alu_src_d;
      branch_p0     <= branch_d;
      mem_write_p0  <= mem_write_d;
      mem_to_reg_p0 <= mem_to_reg_d;
      alu_ctl_p0    <= alu_ctl_d;
    end
  end

  // E -> M: a stall inserts a bubble ahead of the held instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || pcsrc || bus.StallE) begin
      reg_write_p1  <= 1'b0;
      branch_p1     <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
    end else begin
      reg_write_p1  <= reg_write_p0;
      branch_p1     <= branch_p0;
      mem_write_p1  <= mem_write_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
    end
  end

  // M -> W: never stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
    end else begin
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_op <= 1'b0;
    end else if (illegal_d && !pcsrc) begin
      illegal_op <= 1'b1;
    end
  end

  assign bus.IllegalOp = illegal_op;
`endif

  assign bus.j           = j_d;
  assign bus.FlushD      = pcsrc | j_d;
  assign bus.RegDstE     = reg_dst_p0;
  assign bus.ALUSrcB     = alu_src_p0;
  assign bus.ALUControlE = alu_ctl_p0;
  assign bus.RegWriteE   = reg_write_p0;
  assign bus.MemToRegE   = mem_to_reg_p0;
  assign bus.MemWrite    = mem_write_p1;
  assign bus.Branch      = branch_p1;
  assign bus.RegWriteM   = reg_write_p1;
  assign bus.PCSrc       = pcsrc;
  assign bus.RegWriteW   = reg_write_p2;
  assign bus.MemToReg    = mem_to_reg_p2;
endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pipe_controller;
  localparam int ALU_CTL_W = 3;
  localparam int OP_W      = 6;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] NOP  = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FSUB = 6'b100010;
  localparam logic [5:0] FAND = 6'b100100;
  localparam logic [5:0] FOR  = 6'b100101;
  localparam logic [5:0] FSLT = 6'b101010;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_controller_if #(.ALU_CTL_W(ALU_CTL_W), .OP_W(OP_W)) bus ();
  pipe_controller #(.ALU_CTL_W(ALU_CTL_W), .OP_W(OP_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {
    F_J, F_FLUSHD, F_REGDSTE, F_ALUSRCB, F_ALUCTLE, F_REGWRE, F_MEMTOREGE,
    F_MEMWRITE, F_BRANCH, F_REGWRM, F_PCSRC, F_REGWRW, F_MEMTOREG
  } field_t;

  typedef struct {
    int     cyc;
    field_t fld;
    int     val;
    string  name;
  } exp_t;

  exp_t sb[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(field_t f);
    case (f)
      F_J:         return int'(bus.j);
      F_FLUSHD:    return int'(bus.FlushD);
      F_REGDSTE:   return int'(bus.RegDstE);
      F_ALUSRCB:   return int'(bus.ALUSrcB);
      F_ALUCTLE:   return int'(bus.ALUControlE);
      F_REGWRE:    return int'(bus.RegWriteE);
      F_MEMTOREGE: return int'(bus.MemToRegE);
      F_MEMWRITE:  return int'(bus.MemWrite);
      F_BRANCH:    return int'(bus.Branch);
      F_REGWRM:    return int'(bus.RegWriteM);
      F_PCSRC:     return int'(bus.PCSrc);
      F_REGWRW:    return int'(bus.RegWriteW);
      F_MEMTOREG:  return int'(bus.MemToReg);
      default:     return -1;
    endcase
  endfunction

  // monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    int i;
    int a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        a = actual(sb[i].fld);
        checks++;
        if (a != sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d", sb[i].name, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(int off, field_t f, int v, string n);
    exp_t e;
    e.cyc  = cyc + off;
    e.fld  = f;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drive(logic [5:0] op, logic [5:0] fn);
    bus.Opcode = op;
    bus.Funct  = fn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(LW, 6'd0);
    bus.ZeroM  = 1'b0;
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
    tick();

    // reset held with lw in D, then j in D
    for (int i = 0; i < 3; i++) begin
      drive(LW, 6'd0);
      push(0, F_REGWRW, 0, "rst_regwrw");
      push(0, F_MEMWRITE, 0, "rst_memwrite");
      push(0, F_ALUCTLE, 2, "rst_aluctl");
      push(0, F_PCSRC, 0, "rst_pcsrc");
      push(0, F_REGWRE, 0, "rst_regwre");
      tick();
    end
    drive(JMP, 6'd0);
    push(0, F_J, 1, "rst_j");
    push(0, F_FLUSHD, 1, "rst_flushd");
    tick();
    checks++;
    if (bus.j !== 1'b1) begin
      errors++;
      $display("FAIL direct_rst_j: got %0b expected 1", bus.j);
    end
    checks++;
    if (bus.FlushD !== 1'b1) begin
      errors++;
      $display("FAIL direct_rst_flushd: got %0b expected 1", bus.FlushD);
    end
    reset = 1'b1;
    drive(NOP, 6'd0);
    tick();

    // R-type stream
    drive(RT, FSUB);
    push(1, F_ALUCTLE, 6, "sub_alu"); push(1, F_REGDSTE, 1, "sub_regdst");
    push(1, F_REGWRE, 1, "sub_regwre"); push(3, F_REGWRW, 1, "sub_regwrw");
    push(3, F_MEMTOREG, 0, "sub_memtoreg");
    tick();
    drive(RT, FSLT);
    push(1, F_ALUCTLE, 7, "slt_alu"); push(1, F_REGDSTE, 1, "slt_regdst");
    push(3, F_REGWRW, 1, "slt_regwrw");
    tick();
    drive(RT, FAND); push(1, F_ALUCTLE, 0, "and_alu"); tick();
    drive(RT, FOR);  push(1, F_ALUCTLE, 1, "or_alu");  tick();
    drive(RT, FADD); push(1, F_ALUCTLE, 2, "add_alu"); push(2, F_REGWRM, 1, "add_regwrm"); tick();
    drive(RT, 6'b000000);
    push(1, F_ALUCTLE, 2, "badfn_alu"); push(1, F_REGWRE, 0, "badfn_regwre");
    push(3, F_REGWRW, 0, "badfn_regwrw");
    tick();
    drive(NOP, 6'd0);
    push(1, F_ALUCTLE, 2, "nop_alu"); push(1, F_REGWRE, 0, "nop_regwre"); push(1, F_REGDSTE, 0, "nop_regdst");
    tick();
    drive(JMP, 6'd0);
    push(0, F_J, 1, "j_j"); push(0, F_FLUSHD, 1, "j_flushd"); push(1, F_REGWRE, 0, "j_regwre");
    tick();
    drive(NOP, 6'd0); tick(); tick();

    // load
    drive(LW, 6'd0);
    push(1, F_ALUSRCB, 1, "lw_alusrc"); push(1, F_MEMTOREGE, 1, "lw_memtorege");
    push(1, F_REGWRE, 1, "lw_regwre"); push(2, F_MEMWRITE, 0, "lw_memwrite");
    push(3, F_MEMTOREG, 1, "lw_memtoreg"); push(3, F_REGWRW, 1, "lw_regwrw");
    tick();
    drive(NOP, 6'd0); tick(); tick(); tick();

    // branch taken squashes the following sw
    drive(BEQ, 6'd0);
    push(1, F_ALUCTLE, 6, "beq_alu"); push(1, F_ALUSRCB, 0, "beq_alusrc");
    push(2, F_BRANCH, 1, "bt_branch"); push(2, F_PCSRC, 1, "bt_pcsrc"); push(2, F_FLUSHD, 1, "bt_flushd");
    push(3, F_MEMWRITE, 0, "bt_sw_squashed");
    tick();
    drive(SW, 6'd0);
    push(1, F_ALUSRCB, 1, "sw_alusrc"); push(1, F_REGWRE, 0, "sw_regwre");
    tick();
    drive(NOP, 6'd0); bus.ZeroM = 1'b1; tick();
    bus.ZeroM = 1'b0; tick(); tick(); tick();

    // branch not taken lets sw through
    drive(BEQ, 6'd0);
    push(2, F_BRANCH, 1, "bn_branch"); push(2, F_PCSRC, 0, "bn_pcsrc"); push(2, F_FLUSHD, 0, "bn_flushd");
    push(3, F_MEMWRITE, 1, "bn_sw_memwrite");
    tick();
    drive(SW, 6'd0); tick();
    drive(NOP, 6'd0); tick(); tick(); tick();

    // one-cycle stall with addi in E
    drive(ADDI, 6'd0);
    push(1, F_ALUCTLE, 2, "addi_alu"); push(1, F_ALUSRCB, 1, "addi_alusrc");
    push(2, F_ALUSRCB, 1, "stall_hold_alusrc"); push(2, F_ALUCTLE, 2, "stall_hold_alu");
    push(2, F_REGDSTE, 0, "stall_hold_regdst"); push(2, F_REGWRE, 1, "stall_hold_regwre");
    push(2, F_REGWRM, 0, "stall_bubble_m"); push(3, F_REGWRM, 1, "stall_addi_m");
    push(3, F_REGWRW, 0, "stall_bubble_w"); push(4, F_REGWRW, 1, "stall_addi_w");
    tick();
    drive(RT, FSUB); bus.StallE = 1'b1; tick();
    bus.StallE = 1'b0;
    push(1, F_ALUCTLE, 6, "after_stall_alu"); push(1, F_REGDSTE, 1, "after_stall_regdst");
    push(2, F_REGWRM, 1, "after_stall_regwrm");
    tick();
    drive(NOP, 6'd0); tick(); tick(); tick();

    // FlushE together with StallE
    drive(ADDI, 6'd0); tick();
    drive(RT, FSUB); bus.StallE = 1'b1; bus.FlushE = 1'b1;
    push(1, F_ALUSRCB, 0, "fs_alusrc"); push(1, F_REGWRE, 0, "fs_regwre");
    push(1, F_REGDSTE, 0, "fs_regdst"); push(1, F_ALUCTLE, 2, "fs_alu"); push(1, F_REGWRM, 0, "fs_regwrm");
    tick();
    bus.StallE = 1'b0; bus.FlushE = 1'b0;
    drive(NOP, 6'd0); tick(); tick(); tick();

    // FlushE alone
    drive(RT, FSUB); bus.FlushE = 1'b1;
    push(1, F_REGDSTE, 0, "fl_regdst"); push(1, F_ALUCTLE, 2, "fl_alu"); push(1, F_REGWRE, 0, "fl_regwre");
    tick();
    bus.FlushE = 1'b0;
    drive(NOP, 6'd0); tick(); tick(); tick();

    // taken branch beats StallE
    drive(BEQ, 6'd0);
    push(2, F_PCSRC, 1, "ps_pcsrc");
    push(3, F_MEMTOREGE, 0, "ps_memtorege"); push(3, F_ALUSRCB, 0, "ps_alusrc");
    push(3, F_REGDSTE, 0, "ps_regdst"); push(3, F_REGWRM, 0, "ps_regwrm");
    tick();
    drive(LW, 6'd0); push(1, F_MEMTOREGE, 1, "ps_lw_in_e"); tick();
    drive(RT, FSUB); bus.ZeroM = 1'b1; bus.StallE = 1'b1; tick();
    bus.ZeroM = 1'b0; bus.StallE = 1'b0;
    drive(NOP, 6'd0); tick(); tick(); tick();

    // asynchronous reset pulse mid-stream
    drive(LW, 6'd0); tick();
    drive(RT, FSUB); tick();
    drive(NOP, 6'd0);
    push(0, F_REGWRE, 0, "ar_regwre"); push(0, F_REGDSTE, 0, "ar_regdst");
    push(0, F_REGWRM, 0, "ar_regwrm"); push(0, F_MEMTOREGE, 0, "ar_memtorege");
    push(0, F_ALUCTLE, 2, "ar_alu"); push(1, F_REGWRW, 0, "ar_regwrw");
    push(1, F_MEMTOREG, 0, "ar_memtoreg");
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    push(1, F_REGWRW, 0, "ar_regwrw_after"); push(1, F_MEMTOREG, 0, "ar_memtoreg_after");
    tick();

    drive(NOP, 6'd0);
    repeat (5) tick();

    checks++;
    if (bus.RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL direct_idle_regwrw: got %0b expected 0", bus.RegWriteW);
    end
    checks++;
    if (bus.MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL direct_idle_memwrite: got %0b expected 0", bus.MemWrite);
    end
    checks++;
    if (bus.ALUControlE !== 3'b010) begin
      errors++;
      $display("FAIL direct_idle_alu: got %0d expected 2", bus.ALUControlE);
    end
    checks++;
    if (bus.PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL direct_idle_pcsrc: got %0b expected 0", bus.PCSrc);
    end

    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL %s: got unchecked expected check at cyc %0d", sb[k].name, sb[k].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
